mult_nibble_sequencer: RTL and testbench

- Sequential controller that reuses one external 4x4 array multiplier to compute a W x W unsigned product.
- Walks the operand nibble pairs one per cycle, drives the multiplier's m/q inputs and accumulates its 8-bit partial products, shifted into place, into a 2W-bit result.
- Sits between a requester (valid/ready on both sides) and the combinational 4x4 multiplier core.

---
 rtl/mult_nibble_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mult_nibble_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_nibble_sequencer.sv
// Sequential W x W unsigned multiplier that time-shares one external 4x4 core.
// Optional zero-pair skipping is enabled by defining MULT_SKIP_ZERO_EN.
module mult_nibble_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [3:0]     mul_m,
  output logic [3:0]     mul_q,
  input  logic [7:0]     mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           busy
);

  localparam int NB = W / 4;
  localparam int NP = NB * NB;
  localparam int KW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [KW-1:0]  k_q, k_d;

  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [2*W-1:0] pp;
  logic           use_pass;
  int             ki;
  int             ii;
  int             jj;

`ifdef MULT_SKIP_ZERO_EN
  // Bit p set when pass p has both operand nibbles non-zero.
  function automatic logic [NP-1:0] nz_mask(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    nz_mask = '0;
    for (int p = 0; p < NP; p++) begin
      nz_mask[p] = (|x[4*(p%NB) +: 4]) && (|y[4*(p/NB) +: 4]);
    end
  endfunction

  // Lowest set index >= from, or NP if none.
  function automatic int first_at(
    input logic [NP-1:0] m,
    input int            from
  );
    first_at = NP;
    for (int p = NP - 1; p >= 0; p--) begin
      if (p >= from && m[p]) first_at = p;
    end
  endfunction

  int nxt;
`endif

  always_comb begin
    ki    = int'(k_q);
    ii    = ki % NB;
    jj    = ki / NB;
    nib_a = a_q[4*ii +: 4];
    nib_b = b_q[4*jj +: 4];
    pp    = '0;
    pp[7:0] = mul_p;
    pp    = pp << (4 * (ii + jj));
`ifdef MULT_SKIP_ZERO_EN
    use_pass = (|nib_a) && (|nib_b);
`else
    use_pass = 1'b1;
`endif
  end

  // Core inputs are parked at zero whenever no pass is being consumed.
  always_comb begin
    mul_m = 4'd0;
    mul_q = 4'd0;
    if (state_q == MUL && use_pass) begin
      mul_m = nib_a;
      mul_q = nib_b;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
`ifdef MULT_SKIP_ZERO_EN
    nxt     = NP;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          k_d     = '0;
          state_d = MUL;
`ifdef MULT_SKIP_ZERO_EN
          nxt = first_at(nz_mask(a, b), 0);
          if (nxt < NP) k_d = KW'(nxt);
`endif
        end
      end
      MUL: begin
        if (use_pass) acc_d = acc_q + pp;
`ifdef MULT_SKIP_ZERO_EN
        nxt = first_at(nz_mask(a_q, b_q), ki + 1);
        if (nxt < NP) begin
          k_d = KW'(nxt);
        end else begin
          k_d     = '0;
          state_d = DONE;
        end
`else
        if (ki == NP - 1) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_mult_nibble_sequencer.sv
// Scoreboard bench for mult_nibble_sequencer (W=8) with a behavioural 4x4 core.
// Expected pair sequences and latencies follow MULT_SKIP_ZERO_EN when defined.
module tb_mult_nibble_sequencer;

  localparam int W = 8;
`ifdef MULT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   mul_m;
  logic [3:0]   mul_q;
  logic [7:0]   mul_p;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  result;
  logic         busy;

  mult_nibble_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  assign mul_p = {4'd0, mul_m} * {4'd0, mul_q};

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t       rq[$];
  logic [7:0] pq[$];
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pass sequence, latency, result and stability.
  logic seen_v = 1'b0;
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] p;
    if (!rst_n) begin
      seen_v = 1'b0;
    end else begin
      if (busy && !out_valid) begin
        chk("pair_available", int'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          p = pq.pop_front();
          chk("mul_pair", int'({mul_m, mul_q}), int'(p));
        end
      end else begin
        chk("mul_idle_zero", int'({mul_m, mul_q}), 0);
      end
      if (out_valid) begin
        chk("result_expected", int'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          e = rq[0];
          if (!seen_v) chk("latency", int'(($time - 5 - e.t_acc) / 10), e.lat);
          chk("result", int'(result), int'(e.res));
          if (out_ready) void'(rq.pop_front());
        end
      end
      seen_v = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb,
                      input logic [15:0] res, input int lat,
                      input logic [31:0] pairs);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    a = va;
    b = vb;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      e.res = res;
      e.lat = lat;
      e.t_acc = $time;
      rq.push_back(e);
      for (int k = 0; k < lat; k++) pq.push_back(pairs[8*k +: 8]);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && rq.size() != 0; i++) @(negedge clk);
    chk("drain_results_left", rq.size(), 0);
    chk("drain_pairs_left", pq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_mul"}, int'({mul_m, mul_q}), 0);
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hFF, 8'hFF, 16'hFE01, 4, 32'hFFFFFFFF);
    drain();
    send(8'h12, 8'h34, 16'h03A8, 4, 32'h13231424);
    drain();

    // Back-pressure with a competing request held during DONE.
    out_ready = 1'b0;
    send(8'h0A, 8'h0B, 16'h006E, SKIP ? 1 : 4,
         SKIP ? 32'h000000AB : 32'h00A00BAB);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("bp_valid_seen", int'(got), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 8'h55;
      b = 8'h66;
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_valid_held", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_valid", int'(out_valid), 0);
    drain();

    // Reset during pass 2 of FF*FF.
    send(8'hFF, 8'hFF, 16'hFE01, 4, 32'hFFFFFFFF);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    rq.delete();
    pq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h03, 8'h05, 16'h000F, SKIP ? 1 : 4,
         SKIP ? 32'h00000035 : 32'h00300535);
    drain();

    // Back-to-back.
    send(8'h80, 8'h02, 16'h0100, SKIP ? 1 : 4,
         SKIP ? 32'h00000082 : 32'h80008202);
    send(8'h11, 8'h11, 16'h0121, 4, 32'h11111111);
    drain();

    // Zero-nibble patterns.
    send(8'h10, 8'h03, 16'h0030, SKIP ? 1 : 4,
         SKIP ? 32'h00000013 : 32'h10001303);
    drain();
    send(8'h00, 8'h5A, 16'h0000, SKIP ? 1 : 4,
         SKIP ? 32'h00000000 : 32'h05050A0A);
    drain();
    send(8'hFF, 8'hFF, 16'hFE01, 4, 32'hFFFFFFFF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
